// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one single-port memory between the fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN to replace fixed data-over-fetch priority with round robin.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {FETCH, DATA} port_t;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY=%0d outside legal range 1..15", MEM_LATENCY);
  end

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  port_t      owner_q, owner_d;
  logic       store_q, store_d;
  logic       gnt_data, gnt_fetch, data_first;

`ifdef ARB_ROUND_ROBIN_EN
  port_t last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= FETCH;
    end else if (gnt_data || gnt_fetch) begin
      last_grant <= gnt_data ? DATA : FETCH;
    end
  end

  assign data_first = (last_grant == FETCH);
`else
  assign data_first = 1'b1;
`endif

  // Grants are also masked by rst so every output reads 0 while reset is held.
  always_comb begin
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    if (state_q != WAIT && !rst) begin
      gnt_data  = d_req && (!if_req || data_first);
      gnt_fetch = if_req && !gnt_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    store_d = store_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (gnt_data || gnt_fetch) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          owner_d = gnt_data ? DATA : FETCH;
          store_d = gnt_data && d_we;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt_fetch) begin
      mem_addr  = if_addr;
    end
  end

  assign if_ready  = gnt_fetch;
  assign d_ready   = gnt_data;
  assign mem_en    = gnt_data || gnt_fetch;
  assign mem_we    = gnt_data && d_we;
  assign busy      = (state_q == WAIT);
  assign if_rvalid = (state_q == RESP) && (owner_q == FETCH);
  assign d_rvalid  = (state_q == RESP) && (owner_q == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= FETCH;
      store_q  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      store_q <= store_d;
      if (state_q == WAIT && cnt_q == '0) begin
        if (owner_q == FETCH) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= store_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: three instances (latency 1, 2, 4) each with a simple memory,
// driven by directed steps and checked against a response scoreboard.
module tb_mem_arbiter;

  localparam int NI = 3;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        rst       [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        if_ready  [NI];
  logic        if_rvalid [NI];
  logic [31:0] if_rdata  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [31:0] d_addr    [NI];
  logic [31:0] d_wdata   [NI];
  logic        d_ready   [NI];
  logic        d_rvalid  [NI];
  logic [31:0] d_rdata   [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        busy      [NI];

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0062_8293 : (32'hC0DE_0000 | 32'(i));
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    logic        mem_init = 1'b0;

    mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ready(d_ready[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Memory with LAT-cycle read latency; contents set up on the first clock (under reset).
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
        mem_init <= 1'b1;
      end else begin
        if (mem_en[g]) begin
          if (mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
          else           pipe[0] <= mem[mem_addr[g][9:2]];
        end
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sbq    [NI][$];
  bit          glog   [NI][$];
  int          rv_cyc [NI][$];
  logic [31:0] shadow [NI][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_step();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) begin
        sbq[k].delete();
        continue;
      end
      if (if_rvalid[k] || d_rvalid[k]) begin
        rv_cyc[k].push_back(cyc_cnt);
        chk($sformatf("rvalid_excl[%0d]", k), 32'(if_rvalid[k] & d_rvalid[k]), 0);
        chk($sformatf("rvalid_expected[%0d]", k), 32'(sbq[k].size() > 0), 1);
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("rvalid_port[%0d]", k), 32'(d_rvalid[k]), 32'(e.is_data));
          chk($sformatf("rdata[%0d]", k), d_rvalid[k] ? d_rdata[k] : if_rdata[k], e.data);
        end
      end
      if (if_ready[k] || d_ready[k]) begin
        chk($sformatf("ready_excl[%0d]", k), 32'(if_ready[k] & d_ready[k]), 0);
        chk($sformatf("accept_mem_en[%0d]", k), 32'(mem_en[k]), 1);
        if (d_ready[k]) begin
          glog[k].push_back(1'b1);
          chk($sformatf("d_mem_we[%0d]", k), 32'(mem_we[k]), 32'(d_we[k]));
          chk($sformatf("d_mem_addr[%0d]", k), mem_addr[k], d_addr[k]);
          chk($sformatf("d_mem_wdata[%0d]", k), mem_wdata[k], d_wdata[k]);
          if (d_we[k]) begin
            shadow[k][d_addr[k][9:2]] = d_wdata[k];
            sbq[k].push_back('{is_data: 1'b1, data: 32'h0});
          end else begin
            sbq[k].push_back('{is_data: 1'b1, data: shadow[k][d_addr[k][9:2]]});
          end
        end else begin
          glog[k].push_back(1'b0);
          chk($sformatf("f_mem_we[%0d]", k), 32'(mem_we[k]), 0);
          chk($sformatf("f_mem_addr[%0d]", k), mem_addr[k], if_addr[k]);
          chk($sformatf("f_mem_wdata[%0d]", k), mem_wdata[k], 0);
          sbq[k].push_back('{is_data: 1'b0, data: shadow[k][if_addr[k][9:2]]});
        end
      end else begin
        chk($sformatf("idle_bus[%0d]", k),
            mem_addr[k] | mem_wdata[k] | 32'({mem_en[k], mem_we[k]}), 0);
      end
    end
  endtask

  // Drive point is 1 ns after a rising edge; sampling happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    sb_step();
  endtask

  task automatic txn(input int k, input bit is_data, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    bit got = 1'b0;
    if (is_data) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = a;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      smp();
      if (is_data ? d_ready[k] : if_ready[k]) begin
        got = 1'b1;
        chk("txn_mem_we", 32'(mem_we[k]), 32'(is_data & we));
      end
      tick();
    end
    chk("txn_accepted", 32'(got), 1);
    d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    if_req[k] = 1'b0; if_addr[k] = '0;
    got = 1'b0;
    rd = 'x;
    for (int n = 0; n < 20 && !got; n++) begin
      smp();
      if (is_data ? d_rvalid[k] : if_rvalid[k]) begin
        got = 1'b1;
        rd  = is_data ? d_rdata[k] : if_rdata[k];
      end
      tick();
    end
    chk("txn_rvalid_seen", 32'(got), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      smp();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int td, tf, t0, nacc, n0;
    bit got;

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int i = 0; i < 256; i++) shadow[k][i] = init_word(i);
    end
    if_req[0] = 1'b1; if_addr[0] = 32'h40; d_req[0] = 1'b1; d_addr[0] = 32'h44;
    #1;
    chk("rst_if_ready", 32'(if_ready[0]), 0);
    chk("rst_d_ready", 32'(d_ready[0]), 0);
    chk("rst_mem_en", 32'(mem_en[0]), 0);
    chk("rst_mem_addr", mem_addr[0], 0);
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_rvalid", 32'({if_rvalid[k], d_rvalid[k]}), 0);
      chk("rst_if_rdata", if_rdata[k], 0);
      chk("rst_d_rdata", d_rdata[k], 0);
    end
    tick();
    tick();
    if_req[0] = 1'b0; if_addr[0] = '0; d_req[0] = 1'b0; d_addr[0] = '0;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    // Single fetch, latency 1
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    smp();
    chk("sf_if_ready", 32'(if_ready[0]), 1);
    chk("sf_mem_en", 32'(mem_en[0]), 1);
    chk("sf_mem_addr", mem_addr[0], 32'h10);
    tick();
    if_req[0] = 1'b0; if_addr[0] = '0;
    smp();
    chk("sf_busy", 32'(busy[0]), 1);
    chk("sf_rvalid_early", 32'(if_rvalid[0]), 0);
    tick();
    smp();
    chk("sf_rvalid", 32'(if_rvalid[0]), 1);
    chk("sf_rdata", if_rdata[0], 32'h0062_8293);
    tick();
    smp();
    chk("sf_rvalid_once", 32'(if_rvalid[0]), 0);
    chk("sf_busy_done", 32'(busy[0]), 0);
    tick();

    // Simultaneous requests: data first, fetch accepted in the data RESP cycle
    if_req[0] = 1'b1; if_addr[0] = 32'h14;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
    smp();
    chk("cf_d_ready", 32'(d_ready[0]), 1);
    chk("cf_if_wait", 32'(if_ready[0]), 0);
    td = cyc_cnt;
    tick();
    d_req[0] = 1'b0; d_addr[0] = '0;
    got = 1'b0; tf = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      smp();
      if (if_ready[0]) begin
        got = 1'b1;
        tf  = cyc_cnt;
        chk("cf_resp_d_rvalid", 32'(d_rvalid[0]), 1);
      end
      tick();
    end
    if_req[0] = 1'b0; if_addr[0] = '0;
    chk("cf_if_granted", 32'(got), 1);
    chk("cf_back_to_back", 32'(tf - td), 2);
    idle_cycles(6);
    chk("cf_drained", 32'(sbq[0].size()), 0);

    // Both requesters held for six transactions
    glog[0].delete();
    if_req[0] = 1'b1; if_addr[0] = 32'h18;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h1C;
    for (int n = 0; n < 60 && glog[0].size() < 6; n++) begin
      smp();
      tick();
    end
    if_req[0] = 1'b0; if_addr[0] = '0; d_req[0] = 1'b0; d_addr[0] = '0;
    chk("held_grants", 32'(glog[0].size()), 6);
    for (int i = 0; i < 6 && i < glog[0].size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("held_grant%0d", i), 32'(glog[0][i]), 32'(i % 2 == 0));
`else
      chk($sformatf("held_grant%0d", i), 32'(glog[0][i]), 1);
`endif
    end
    idle_cycles(6);
    chk("held_drained", 32'(sbq[0].size()), 0);

    // Store then load
    txn(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, rd);
    chk("store_ack_rdata", rd, 0);
    txn(0, 1'b1, 1'b0, 32'h100, 32'h0, rd);
    chk("load_rdata", rd, 32'hDEAD_BEEF);

    // Reset mid-transaction, latency 2
    txn(1, 1'b0, 1'b0, 32'h14, 32'h0, rd);
    chk("rt_pre_fetch", rd, 32'hC0DE_0005);
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    smp();
    chk("rt_accept", 32'(if_ready[1]), 1);
    tick();
    if_req[1] = 1'b0; if_addr[1] = '0;
    smp();
    chk("rt_busy_before", 32'(busy[1]), 1);
    #2;
    rst[1] = 1'b1;
    #1;
    chk("rt_busy", 32'(busy[1]), 0);
    chk("rt_if_rdata", if_rdata[1], 0);
    chk("rt_rvalid", 32'({if_rvalid[1], d_rvalid[1]}), 0);
    chk("rt_mem", 32'({mem_en[1], mem_we[1]}) | mem_addr[1], 0);
    tick();
    smp();
    tick();
    smp();
    tick();
    n0 = rv_cyc[1].size();
    rst[1] = 1'b0;
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    smp();
    chk("rt_reaccept", 32'(if_ready[1]), 1);
    tick();
    if_req[1] = 1'b0; if_addr[1] = '0;
    idle_cycles(8);
    chk("rt_one_rvalid", 32'(rv_cyc[1].size() - n0), 1);

    // Latency sweep: three back-to-back fetches at latency 4
    rv_cyc[2].delete();
    if_req[2] = 1'b1; if_addr[2] = 32'h0;
    nacc = 0; t0 = 0;
    for (int n = 0; n < 60 && nacc < 3; n++) begin
      smp();
      if (if_ready[2]) begin
        if (nacc == 0) t0 = cyc_cnt;
        nacc++;
      end
      tick();
      if (nacc < 3) if_addr[2] = 32'(nacc * 4);
      else begin
        if_req[2] = 1'b0; if_addr[2] = '0;
      end
    end
    if_req[2] = 1'b0; if_addr[2] = '0;
    chk("sw_accepts", 32'(nacc), 3);
    for (int n = 0; n < 40 && rv_cyc[2].size() < 3; n++) begin
      smp();
      tick();
    end
    chk("sw_rvalids", 32'(rv_cyc[2].size()), 3);
    for (int i = 0; i < 3 && i < rv_cyc[2].size(); i++) begin
      chk($sformatf("sw_rvalid_cycle%0d", i), 32'(rv_cyc[2][i] - t0), 32'(5 * (i + 1)));
    end
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
